// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART-to-bus debug bridge.
// Command/reply byte values, FSM states and a width helper.
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RESP,
        TXWAIT
    } state_t;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    localparam int TX_GUARD = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_bus_bridge_if.sv
// picorv32-native bus between the bridge (master) and an arbiter port.
// Address is word aligned; wstrb is all-or-nothing.
interface uart_bus_bridge_if;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/uart_bridge_txseq.sv
// Reply sequencer: sends 1 or 4 bytes of a word, LSB first,
// pacing each byte on the uart transmitter busy flag.
module uart_bridge_txseq
    import uart_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] word,
    input  logic [2:0]  count,
    input  logic        tx_busy,
    output logic        tx_load,
    output logic [7:0]  tx_data,
    output logic        done
);

    localparam int GW = clog2(TX_GUARD + 1);

    state_t      state;
    state_t      nxt;
    logic [31:0] sh;
    logic [2:0]  left;
    logic [GW-1:0] guard;
    logic        seen;
    logic        byte_done;

    assign tx_data = sh[7:0];

    // busy never rising within the guard window counts as sent
    assign byte_done = !tx_busy &&
                       (seen || guard >= GW'(TX_GUARD - 1));

    // state register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= nxt;
    end

    // next state, load strobe and completion
    always_comb begin
        nxt     = state;
        tx_load = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: if (start) nxt = RESP;
            RESP: begin
                if (!tx_busy) begin
                    tx_load = 1'b1;
                    nxt     = TXWAIT;
                end
            end
            TXWAIT: begin
                if (byte_done) begin
                    if (left == 3'd1) begin
                        done = 1'b1;
                        nxt  = IDLE;
                    end else begin
                        nxt = RESP;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // reply word, byte count and per-byte busy tracking
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sh    <= '0;
            left  <= '0;
            guard <= '0;
            seen  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                sh   <= word;
                left <= count;
            end
            if (state == RESP) begin
                guard <= '0;
                seen  <= 1'b0;
            end
            if (state == TXWAIT) begin
                if (tx_busy) seen <= 1'b1;
                if (guard != GW'(TX_GUARD)) guard <= guard + GW'(1);
                if (byte_done && left != 3'd1) begin
                    sh   <= sh >> 8;
                    left <= left - 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_bus_bridge.sv
// Host debug bridge: W/R byte commands from the uart become
// single bus accesses; replies go back through the sequencer.
module uart_bus_bridge
    import uart_bridge_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 1200000,
    parameter int BUS_TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    output logic              tx_load,
    output logic [7:0]        tx_data,
    uart_bus_bridge_if.master bus,
    output logic              busy
);

    localparam int RW = clog2(BYTE_TIMEOUT + 1);
    localparam int MW = clog2(BUS_TIMEOUT + 1);

    state_t        state;
    state_t        nxt;
    logic          op_wr;
    logic [1:0]    idx;
    logic [RW-1:0] rtim;
    logic [MW-1:0] mtim;
    logic          is_op;
    logic          rx_on;
    logic          rx_exp;
    logic          rx_take;
    logic          last;
    logic          bus_hit;
    logic          bus_to;
    logic          tx_start;
    logic          tx_done;
    logic [31:0]   tx_word;
    logic [2:0]    tx_cnt;

    assign is_op   = rx_data == OP_WR || rx_data == OP_RD;
    assign rx_on   = state == ADDR || state == DATA;
    assign rx_exp  = rx_on && rtim == RW'(BYTE_TIMEOUT - 1);
    assign rx_take = rx_on && rx_valid && !rx_exp;
    assign last    = idx == 2'd3;
    assign bus_hit = state == BUS && bus.mem_valid && bus.mem_ready;
    assign bus_to  = state == BUS && bus.mem_valid && !bus.mem_ready &&
                     mtim == MW'(BUS_TIMEOUT - 1);
    assign tx_start = bus_hit || bus_to;
    assign tx_word  = bus_to ? {24'h0, RSP_ERR} :
                      op_wr  ? {24'h0, RSP_OK}  : bus.mem_rdata;
    assign tx_cnt   = (bus_to || op_wr) ? 3'd1 : 3'd4;
    assign busy     = state != IDLE;
    assign bus.mem_wstrb = (bus.mem_valid && op_wr) ? 4'hF : 4'h0;

    // state register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= nxt;
    end

    // command decode and access sequencing
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (rx_valid && is_op) nxt = ADDR;
            ADDR: begin
                if (rx_exp)
                    nxt = IDLE;
                else if (rx_take && last)
                    nxt = op_wr ? DATA : BUS;
            end
            DATA: begin
                if (rx_exp)
                    nxt = IDLE;
                else if (rx_take && last)
                    nxt = BUS;
            end
            BUS:  if (tx_start) nxt = RESP;
            RESP: if (tx_done) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // field shifters, timers and the bus request
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_wr         <= 1'b0;
            idx           <= '0;
            rtim          <= '0;
            mtim          <= '0;
            bus.mem_valid <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            if (state == IDLE) begin
                idx  <= '0;
                rtim <= '0;
                if (rx_valid && is_op) op_wr <= rx_data == OP_WR;
            end
            if (rx_take) begin
                rtim <= '0;
                idx  <= last ? 2'd0 : idx + 2'd1;
                if (state == ADDR)
                    bus.mem_addr <= {rx_data, bus.mem_addr[31:10], 2'b00};
                else
                    bus.mem_wdata <= {rx_data, bus.mem_wdata[31:8]};
            end else if (rx_on && rtim != RW'(BYTE_TIMEOUT)) begin
                rtim <= rtim + RW'(1);
            end
            if (state == BUS) begin
                bus.mem_valid <= !tx_start;
                if (bus.mem_valid && !bus.mem_ready &&
                    mtim != MW'(BUS_TIMEOUT))
                    mtim <= mtim + MW'(1);
            end else begin
                mtim <= '0;
            end
        end
    end

    uart_bridge_txseq u_txseq (
        .clk     (clk),
        .resetn  (resetn),
        .start   (tx_start),
        .word    (tx_word),
        .count   (tx_cnt),
        .tx_busy (tx_busy),
        .tx_load (tx_load),
        .tx_data (tx_data),
        .done    (tx_done)
    );

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: commands feed expectation
// queues; bus and tx monitors pop and compare independently.
module tb_uart_bus_bridge;

    localparam int BYTE_TO = 100;
    localparam int BUS_TO  = 255;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        tmo;
    } bus_exp_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h0;
    logic       tx_busy = 1'b0;
    logic       tx_load;
    logic [7:0] tx_data;
    logic       busy;

    uart_bus_bridge_if bus();

    int checks = 0;
    int errors = 0;
    int tx_count = 0;
    int lat = 3;
    int bmin = 2;
    int bmax = 8;
    bit stall_bus = 1'b0;
    bit quiet_tx = 1'b0;

    bus_exp_t   exp_bus[$];
    logic [7:0] exp_tx[$];
    logic [31:0] ref_mem [bit [31:0]];
    logic [31:0] slv_mem [bit [31:0]];

    uart_bus_bridge #(
        .BYTE_TIMEOUT (BYTE_TO),
        .BUS_TIMEOUT  (BUS_TO)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_busy  (tx_busy),
        .tx_load  (tx_load),
        .tx_data  (tx_data),
        .bus      (bus),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fill(logic [31:0] a);
        return a ^ 32'hA5C3_0F96;
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        tick($urandom_range(0, 4));
    endtask

    // mode 0: normal, 1: bus stalls to timeout, 2: stalled, to be reset
    task automatic issue(bit wr, logic [31:0] a, logic [31:0] d, int mode);
        bus_exp_t e;
        logic [31:0] w;
        logic [31:0] v;
        w = {a[31:2], 2'b00};
        e.addr  = w;
        e.wdata = d;
        e.wstrb = wr ? 4'hF : 4'h0;
        e.tmo   = (mode == 1);
        exp_bus.push_back(e);
        stall_bus = (mode != 0);
        if (mode == 1) begin
            exp_tx.push_back(8'h45);
        end else if (mode == 0) begin
            if (wr) begin
                ref_mem[w] = d;
                exp_tx.push_back(8'h4B);
            end else begin
                v = ref_rd(w);
                for (int i = 0; i < 4; i++) exp_tx.push_back(v[8*i +: 8]);
            end
        end
        send(wr ? 8'h57 : 8'h52);
        for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
        if (wr) for (int i = 0; i < 4; i++) send(d[8*i +: 8]);
    endtask

    task automatic wait_idle(string name);
        int n;
        n = 0;
        while ((busy || exp_tx.size() > 0 || exp_bus.size() > 0) &&
               n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_complete"}, 32'(n >= 3000), 32'd0);
        tick(2);
    endtask

    // bus responder backed by its own memory
    initial begin : slave
        int wc;
        wc = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (bus.mem_valid && !stall_bus && resetn) begin
                if (wc >= lat) begin
                    wc = 0;
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = slv_mem.exists(bus.mem_addr) ?
                                    slv_mem[bus.mem_addr] :
                                    fill(bus.mem_addr);
                    if (bus.mem_wstrb == 4'hF)
                        slv_mem[bus.mem_addr] = bus.mem_wdata;
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
        end
    end

    // bus monitor: each access against the next expectation
    initial begin : bus_mon
        bus_exp_t cur;
        bit have;
        bit prev;
        int dur;
        cur  = '0;
        have = 1'b0;
        prev = 1'b0;
        dur  = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_valid && !prev) begin
                dur  = 0;
                have = exp_bus.size() > 0;
                if (have) begin
                    cur = exp_bus.pop_front();
                    chk("bus_addr", bus.mem_addr, cur.addr);
                    chk("bus_wstrb", {28'h0, bus.mem_wstrb},
                        {28'h0, cur.wstrb});
                    if (cur.wstrb == 4'hF)
                        chk("bus_wdata", bus.mem_wdata, cur.wdata);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: access to %h, none expected",
                             bus.mem_addr);
                end
            end
            if (bus.mem_valid)
                dur++;
            else if (prev && have && cur.tmo)
                chk("bus_timeout_len", dur, BUS_TO);
            prev = bus.mem_valid;
        end
    end

    // tx monitor plus uart transmitter busy model
    initial begin : tx_mon
        bit pend;
        int bc;
        logic [7:0] e;
        pend = 1'b0;
        bc   = 0;
        forever begin
            @(negedge clk);
            if (tx_load) begin
                tx_count++;
                chk("tx_load_idle", {31'h0, tx_busy}, 32'h0);
                if (exp_tx.size() > 0) begin
                    e = exp_tx.pop_front();
                    chk("tx_byte", {24'h0, tx_data}, {24'h0, e});
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: byte %h, none expected",
                             tx_data);
                end
                pend = 1'b1;
            end else if (pend) begin
                pend = 1'b0;
                bc   = quiet_tx ? 0 : $urandom_range(bmin, bmax);
            end else if (bc > 0) begin
                bc--;
            end
            tx_busy = bc > 0;
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int c0;
        tick(3);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_tx_load", {31'h0, tx_load}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_mem_valid", {31'h0, bus.mem_valid}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
        resetn = 1'b1;
        tick(2);

        lat = 3;
        issue(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0);
        wait_idle("write");

        ref_mem[32'h1004] = 32'h1234_5678;
        slv_mem[32'h1004] = 32'h1234_5678;
        issue(1'b0, 32'h0000_1007, 32'h0, 0);
        wait_idle("read");

        issue(1'b0, 32'h0000_2000, 32'h0, 1);
        wait_idle("bus_timeout");
        stall_bus = 1'b0;
        chk("bus_timeout_busy", {31'h0, busy}, 32'h0);

        send(8'h57);
        send(8'h00);
        send(8'h10);
        tick(BYTE_TO + 50);
        chk("byte_timeout_busy", {31'h0, busy}, 32'h0);
        issue(1'b0, 32'h0000_1000, 32'h0, 0);
        wait_idle("after_byte_timeout");

        send(8'h41);
        tick(3);
        chk("noise_busy", {31'h0, busy}, 32'h0);

        bmin = 12;
        bmax = 12;
        issue(1'b0, 32'h0000_1004, 32'h0, 0);
        c0 = tx_count;
        n  = 0;
        while (tx_count == c0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("inject_reply_start", 32'(n >= 2000), 32'd0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = (i == 0) ? 8'h57 : 8'($urandom);
            @(negedge clk);
            rx_valid = 1'b0;
        end
        wait_idle("inject");
        bmin = 2;
        bmax = 8;

        issue(1'b0, 32'h0000_3000, 32'h0, 2);
        n = 0;
        while (!bus.mem_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_access_seen", {31'h0, bus.mem_valid}, 32'h1);
        tick(5);
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_mem_valid", {31'h0, bus.mem_valid}, 32'h0);
        chk("abort_tx_load", {31'h0, tx_load}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        resetn = 1'b1;
        stall_bus = 1'b0;
        tick(2);
        issue(1'b1, 32'h0000_3000, 32'hCAFE_F00D, 0);
        wait_idle("post_reset_write");
        issue(1'b0, 32'h0000_3002, 32'h0, 0);
        wait_idle("post_reset_read");

        for (int k = 0; k < 24; k++) begin
            lat      = $urandom_range(0, 5);
            quiet_tx = $urandom_range(0, 3) == 0;
            issue($urandom_range(0, 1) == 1,
                  32'h4000 + 32'($urandom_range(0, 7) * 4) +
                  32'($urandom_range(0, 3)),
                  $urandom,
                  ($urandom_range(0, 7) == 0) ? 1 : 0);
            wait_idle("random");
            stall_bus = 1'b0;
        end

        chk("bus_queue_empty", exp_bus.size(), 32'd0);
        chk("tx_queue_empty", exp_tx.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
